// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller.
// Owns the fetch PC and drives the combinational instruction ROM. Each
// returned word is tagged with its PC and captured into a 2-entry queue that
// decode drains. Redirects flush the queue and restart fetch. Illegal fetch
// addresses (misaligned or beyond the ROM) become a single tagged fault
// entry, after which fetch stalls until the next redirect.
//
// Handshake: the queue head is transferred to decode on every rising edge
// where inst_valid and inst_ready are both high. inst_valid never depends on
// inst_ready. While inst_valid is high and inst_ready is low, inst, inst_pc
// and inst_fault hold steady until a redirect or reset.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        dbg_state
);

    localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] q_inst  [2];
    logic [31:0] q_pc    [2];
    logic        q_fault [2];
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        rd_ptr;
    logic        wr_ptr;

    logic        pc_legal;
    logic        pop;
    logic        space;
    logic        push;

    // Current fetch address is legal when word aligned and inside the ROM.
    assign pc_legal = (fetch_pc[1:0] == 2'b00) && (fetch_pc <= LAST_PC);

    assign rom_addr = fetch_pc;
    assign dbg_state = (state == FAULT);

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid && inst_ready;
    assign space      = (count < 2'd2) || pop;
    // A redirect discards anything fetched this cycle, so no push then.
    assign push       = (state == RUN) && space && !redirect_valid;

    // Queue head drives decode; empty queue shows a clean NOP bubble.
    always_comb begin
        inst       = NOP;
        inst_pc    = 32'h0;
        inst_fault = 1'b0;
        if (inst_valid) begin
            inst       = q_inst[rd_ptr];
            inst_pc    = q_pc[rd_ptr];
            inst_fault = q_fault[rd_ptr];
        end
    end

    // Next FSM state and queue occupancy.
    always_comb begin
        state_next = state;
        count_next = count;
        if (redirect_valid) begin
            state_next = RUN;
            count_next = 2'd0;
        end else begin
            if (push && !pc_legal) begin
                state_next = FAULT;
            end
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Fetch PC, queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= ~wr_ptr;
                // A fault holds the PC so the faulting address stays visible.
                if (pc_legal) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Queue storage; entries are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr]  <= pc_legal ? rom_data : NOP;
            q_pc[wr_ptr]    <= fetch_pc;
            q_fault[wr_ptr] <= !pc_legal;
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl. The ROM returns word k at address 4k.
module tb_ifetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    // Clock and ROM model.
    always #5 clk = ~clk;
    assign rom_data = {2'b00, rom_addr[31:2]};

    ifetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .MEM_SIZE(1024),
        .NOP(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_fault(inst_fault),
        .dbg_state(dbg_state)
    );

    // Advance one rising edge; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] word,
                            input logic fault);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst, word);
        chk({tag, "_fault"}, {31'b0, inst_fault}, {31'b0, fault});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
        chk({tag, "_inst"}, inst, NOP);
        chk({tag, "_pc"}, inst_pc, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        @(negedge clk);

        // Reset state.
        do_reset();
        chk_empty("rst");
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_fault", {31'b0, inst_fault}, 32'd0);
        chk("rst_state", {31'b0, dbg_state}, 32'd0);

        // Sequential fetch at one instruction per cycle.
        for (int k = 0; k < 6; k++) begin
            step();
            chk_head($sformatf("seq%0d", k), 32'(4 * k), 32'(k), 1'b0);
        end

        // Backpressure: queue fills with 0x0 and 0x4, fetch parks at 0x8.
        do_reset();
        inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_head($sformatf("bp_hold%0d", k), 32'h0, 32'd0, 1'b0);
        end
        chk("bp_addr", rom_addr, 32'h8);
        inst_ready = 1'b1;
        step();
        chk_head("bp_rel0", 32'h4, 32'd1, 1'b0);
        step();
        chk_head("bp_rel1", 32'h8, 32'd2, 1'b0);
        step();
        chk_head("bp_rel2", 32'hC, 32'd3, 1'b0);

        // Redirect while full and popping in the same cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        chk_empty("rd_flush");
        chk("rd_addr", rom_addr, 32'h40);
        step();
        chk_head("rd_tgt", 32'h40, 32'h10, 1'b0);
        step();
        chk_head("rd_next", 32'h44, 32'h11, 1'b0);

        // Misaligned redirect yields one fault entry, then idle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        inst_ready     = 1'b0;
        step();
        redirect_valid = 1'b0;
        chk_empty("mis_flush");
        step();
        chk_head("mis_head", 32'h42, NOP, 1'b1);
        chk("mis_state", {31'b0, dbg_state}, 32'd1);
        step();
        chk_head("mis_stable", 32'h42, NOP, 1'b1);
        inst_ready = 1'b1;
        step();
        chk_empty("mis_drain");
        step();
        chk_empty("mis_idle");
        chk("mis_addr", rom_addr, 32'h42);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        redirect_valid = 1'b0;
        chk_empty("mis_rd");
        chk("mis_rd_state", {31'b0, dbg_state}, 32'd0);
        step();
        chk_head("mis_resume", 32'h10, 32'h4, 1'b0);

        // End of ROM: two legal words, then a fault at 0x400.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3F8;
        step();
        redirect_valid = 1'b0;
        chk_empty("eor_flush");
        step();
        chk_head("eor0", 32'h3F8, 32'hFE, 1'b0);
        step();
        chk_head("eor1", 32'h3FC, 32'hFF, 1'b0);
        step();
        chk_head("eor2", 32'h400, NOP, 1'b1);
        step();
        chk_empty("eor_idle0");
        step();
        chk_empty("eor_idle1");
        chk("eor_addr", rom_addr, 32'h400);

        // Reset mid-run with a full queue overrides a simultaneous redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        inst_ready     = 1'b0;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk_head("mr_full", 32'h100, 32'h40, 1'b0);
        chk("mr_full_addr", rom_addr, 32'h108);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        chk_empty("mr_rst");
        chk("mr_addr", rom_addr, 32'h0);
        step();
        chk_head("mr_res0", 32'h0, 32'd0, 1'b0);
        step();
        chk_head("mr_res1", 32'h4, 32'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller that sequences the combinational instruction ROM. It owns the fetch PC and drives the ROM address each cycle. Returned instructions are captured, tagged with their PC, into a 2-entry queue that decode drains through a valid/ready handshake. Redirects (branch, jump, trap) flush the queue and restart fetch. Misaligned or out-of-range fetch addresses are reported to decode as tagged faults, not silently replaced.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- MEM_SIZE, 1024, ROM size in bytes; last legal fetch address is MEM_SIZE-4
- NOP, 32'h0000_0013, instruction word placed in fault entries and on inst when the queue is empty

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rom_addr  output  32  ROM address; always equals fetch_pc (combinational from register)
- rom_data  input  32  ROM instruction word, combinationally valid in the same cycle as rom_addr
- redirect_valid  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address
- inst_valid  output  1  queue head valid
- inst_ready  input  1  decode accepts queue head
- inst  output  32  queue-head instruction
- inst_pc  output  32  PC of the queue-head instruction
- inst_fault  output  1  queue head is a fetch fault (misaligned or out of range)

## Operation
- State: fetch_pc (32 b), 2-entry circular queue of {inst, pc, fault}, count (2 b), rd/wr pointers, FSM {RUN, FAULT}.
- Legal PC: pc[1:0]==0 and pc <= MEM_SIZE-4, compared as unsigned 32-bit.
- pop = inst_valid & inst_ready. Space is available when count<2, or when count==2 and pop is asserted the same cycle.
- RUN, no redirect, space available:
  - Legal PC: push {rom_data, fetch_pc, 0}; fetch_pc <= fetch_pc+4, wrapping mod 2^32.
  - Illegal PC: push {NOP, fetch_pc, 1}; go to FAULT; fetch_pc is held.
- RUN, no space: no push; fetch_pc is held, and rom_addr stays stable.
- FAULT: no pushes. Queued entries continue to drain normally. Exit only via redirect or reset.
- Redirect (highest priority, in any state):
  - Queue flushes to count=0. Any same-cycle pop and push are discarded.
  - fetch_pc <= redirect_pc; state <= RUN.
  - The legality of the new PC is evaluated on the following cycle.
- Simultaneous pop and push with count==2 or count==1: count is unchanged, and both pointers advance.
- Outputs come from the queue head.
  - count==0: inst_valid=0, inst=NOP, inst_pc=0, inst_fault=0.

## Timing
- Reset values (in effect the cycle after rst is sampled high):
  - fetch_pc=RESET_PC, so rom_addr=RESET_PC.
  - count=0, pointers=0, state=RUN.
  - inst_valid=0, inst=NOP, inst_pc=0, inst_fault=0.
- rst asserted mid-operation discards all queue contents and any fault state in that edge. It overrides redirect_valid.
- Fetch latency: an address is presented in cycle N and appears at the queue head in cycle N+1 (inst_valid=1), provided the queue was empty.
- Steady-state throughput is 1 instruction/cycle while inst_ready=1.
- Redirect latency: redirect_valid is sampled at edge N. inst_valid=0 in cycle N+1, and the redirect-target instruction is at the head in cycle N+2.
- inst, inst_pc and inst_fault stay stable while inst_valid=1 and inst_ready=0, unless a redirect or reset occurs.
- No combinational path exists from inst_ready or redirect_valid to rom_addr. A combinational path from rom_data to inst does not exist either, because inst is registered in the queue.

## Test plan
- Sequential fetch: reset with RESET_PC=0, hold inst_ready=1, ROM words k at address 4k.
  - Required: inst_valid rises 1 cycle after reset release, then inst_pc = 0,4,8,… with inst = 0,1,2,… on consecutive cycles.
- Backpressure: hold inst_ready=0 for 5 cycles after start.
  - Required: count saturates at 2 and rom_addr holds 0x8.
  - On release: heads 0x0 and 0x4 emerge, then 0x8, with no duplicate or lost PC.
- Redirect with full queue: queue full, redirect_valid=1 with redirect_pc=0x40, inst_ready=1 in the same cycle.
  - Required: the next cycle has inst_valid=0, then inst_pc=0x40.
  - Prior entries are never re-presented, and the popped entry is not counted.
- Misaligned redirect: redirect_pc=0x42.
  - Required: the head is {NOP, 0x42, fault=1}, followed by no further valid entries.
  - A subsequent redirect to 0x10 resumes at 0x10 with fault=0.
- End of ROM: redirect to 0x3F8 with MEM_SIZE=1024.
  - Required: valid entries at 0x3F8 and 0x3FC, then fault entry at 0x400, then idle.
- Reset mid-run: assert rst for 1 cycle with a full queue and redirect_valid=1.
  - Required: inst_valid=0, rom_addr=RESET_PC, and fetch resumes from RESET_PC, ignoring the redirect.
